// File: rtl/multicycle_control.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : multicycle_control
// Description : Multicycle control unit for an RV32 subset (addi, srai, add,
//               lw, sw, beq, jal, jalr). Sequences FETCH/DECODE/EXEC/MEM,
//               owns PC and IR, and traps illegal encodings in HALT.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
  parameter int NBITS      = 8,
  parameter int NREGS      = 32,
  parameter int WIDTH_ALUF = 4,
  localparam int RIDX      = $clog2(NREGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [NBITS-1:0]      InstrAddr,
  output logic                  InstrReq,
  input  logic [31:0]           Instruction,
  input  logic                  InstrReady,
  output logic [RIDX-1:0]       RS1,
  output logic [RIDX-1:0]       RS2,
  output logic [RIDX-1:0]       RD,
  output logic [NBITS-1:0]      IMM,
  output logic [WIDTH_ALUF-1:0] ALUControl,
  output logic                  ALUSrc,
  output logic                  MemtoReg,
  output logic                  RegWrite,
  output logic                  link,
  output logic [NBITS-1:0]      pclink,
  input  logic [NBITS-1:0]      PCReg,
  input  logic                  Zero,
  output logic                  MemReq,
  output logic                  MemWrite,
  input  logic                  MemReady,
  output logic [NBITS-1:0]      PC,
  output logic                  Halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    OP_ILL  = 4'd0,
    OP_ADDI = 4'd1,
    OP_SRAI = 4'd2,
    OP_ADD  = 4'd3,
    OP_LW   = 4'd4,
    OP_SW   = 4'd5,
    OP_BEQ  = 4'd6,
    OP_JAL  = 4'd7,
    OP_JALR = 4'd8
  } op_e;

  state_e           state_q, state_d;
  logic [NBITS-1:0] pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;

  op_e              op;
  logic [31:0]      imm32;
  logic [NBITS-1:0] pc_plus4;
  logic [NBITS-1:0] jalr_sum;

  assign pc_plus4  = pc_q + NBITS'(4);
  assign jalr_sum  = PCReg + IMM;
  assign PC        = pc_q;
  assign InstrAddr = pc_q;
  assign pclink    = pc_plus4;
  assign Halted    = (state_q == S_HALT);
  assign RS1       = RIDX'(ir_q[19:15]);
  assign RS2       = RIDX'(ir_q[24:20]);
  assign RD        = RIDX'(ir_q[11:7]);
  // Sign-extended 32-bit immediate narrowed (or widened) to the datapath width.
  assign IMM       = NBITS'($signed(imm32));

  // Classify the held instruction; anything outside the supported set is illegal.
  always_comb begin
    op = OP_ILL;
    unique case (ir_q[6:0])
      7'b0010011: begin
        if (ir_q[14:12] == 3'b000)
          op = OP_ADDI;
        else if (ir_q[14:12] == 3'b101 && ir_q[31:25] == 7'b0100000)
          op = OP_SRAI;
      end
      7'b0110011: if (ir_q[14:12] == 3'b000 && ir_q[31:25] == 7'b0000000) op = OP_ADD;
      7'b0000011: if (ir_q[14:12] == 3'b010) op = OP_LW;
      7'b0100011: if (ir_q[14:12] == 3'b010) op = OP_SW;
      7'b1100011: if (ir_q[14:12] == 3'b000) op = OP_BEQ;
      7'b1101111: op = OP_JAL;
      7'b1100111: if (ir_q[14:12] == 3'b000) op = OP_JALR;
      default:    op = OP_ILL;
    endcase
  end

  // Immediate extraction by instruction format, plus ALU operation selection.
  always_comb begin
    imm32      = 32'd0;
    ALUControl = '0;
    ALUSrc     = 1'b0;
    unique case (ir_q[6:0])
      7'b0010011, 7'b0000011, 7'b1100111:
        imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
      7'b0100011:
        imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      7'b1100011:
        imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      7'b1101111:
        imm32 = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      default:
        imm32 = 32'd0;
    endcase
    unique case (op)
      OP_ADDI, OP_LW, OP_SW, OP_JALR: begin
        ALUControl = WIDTH_ALUF'(4'b0010);
        ALUSrc     = 1'b1;
      end
      OP_ADD:  ALUControl = WIDTH_ALUF'(4'b0010);
      OP_SRAI: begin
        ALUControl = WIDTH_ALUF'(4'b1101);
        ALUSrc     = 1'b1;
      end
      OP_BEQ:  ALUControl = WIDTH_ALUF'(4'b0110);
      default: ALUControl = '0;
    endcase
  end

  // Next-state, PC/IR update and strobe generation; strobes default low.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    InstrReq = 1'b0;
    RegWrite = 1'b0;
    MemReq   = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    link     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        InstrReq = 1'b1;
        if (InstrReady) begin
          ir_d    = Instruction;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = (op == OP_ILL) ? S_HALT : S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        unique case (op)
          OP_ADDI, OP_SRAI, OP_ADD: begin
            RegWrite = 1'b1;
            pc_d     = pc_plus4;
          end
          OP_LW, OP_SW: state_d = S_MEM;
          OP_BEQ: pc_d = Zero ? (pc_q + IMM) : pc_plus4;
          OP_JAL: begin
            link     = 1'b1;
            RegWrite = 1'b1;
            pc_d     = pc_q + IMM;
          end
          OP_JALR: begin
            link     = 1'b1;
            RegWrite = 1'b1;
            pc_d     = jalr_sum & ~NBITS'(1);
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        MemReq   = 1'b1;
        MemWrite = (op == OP_SW);
        if (MemReady) begin
          RegWrite = (op == OP_LW);
          MemtoReg = (op == OP_LW);
          pc_d     = pc_plus4;
          state_d  = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // State, PC and IR registers; reset overrides every other event.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
`timescale 1ns/1ps
module tb_multicycle_control;

  localparam int K_ADDI = 0, K_SRAI = 1, K_ADD = 2, K_LW = 3,
                 K_SW = 4, K_BEQ = 5, K_JAL = 6, K_JALR = 7;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  InstrAddr, IMM, pclink, PCReg, PC;
  logic        InstrReq, InstrReady, ALUSrc, MemtoReg, RegWrite, link;
  logic        Zero, MemReq, MemWrite, MemReady, Halted;
  logic [31:0] Instruction;
  logic [4:0]  RS1, RS2, RD;
  logic [3:0]  ALUControl;

  int checks = 0;
  int errors = 0;
  logic [7:0] mpc;

  multicycle_control #(.NBITS(8), .NREGS(32), .WIDTH_ALUF(4)) dut (
    .clock(clock), .reset(reset), .InstrAddr(InstrAddr), .InstrReq(InstrReq),
    .Instruction(Instruction), .InstrReady(InstrReady), .RS1(RS1), .RS2(RS2),
    .RD(RD), .IMM(IMM), .ALUControl(ALUControl), .ALUSrc(ALUSrc),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .link(link), .pclink(pclink),
    .PCReg(PCReg), .Zero(Zero), .MemReq(MemReq), .MemWrite(MemWrite),
    .MemReady(MemReady), .PC(PC), .Halted(Halted)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Assemble an RV32 word from a kind, register numbers and an integer immediate.
  function automatic logic [31:0] enc(input int k, input int rd, input int rs1,
                                      input int rs2, input int imm);
    logic [31:0] v;
    logic [4:0]  d, s1, s2;
    v = imm; d = 5'(rd); s1 = 5'(rs1); s2 = 5'(rs2);
    case (k)
      K_ADDI:  enc = {v[11:0], s1, 3'b000, d, 7'b0010011};
      K_SRAI:  enc = {7'b0100000, v[4:0], s1, 3'b101, d, 7'b0010011};
      K_ADD:   enc = {7'b0000000, s2, s1, 3'b000, d, 7'b0110011};
      K_LW:    enc = {v[11:0], s1, 3'b010, d, 7'b0000011};
      K_SW:    enc = {v[11:5], s2, s1, 3'b010, v[4:0], 7'b0100011};
      K_BEQ:   enc = {v[12], v[10:5], s2, s1, 3'b000, v[4:1], v[11], 7'b1100011};
      K_JAL:   enc = {v[20], v[10:1], v[11], v[19:12], d, 7'b1101111};
      default: enc = {v[11:0], s1, 3'b000, d, 7'b1100111};
    endcase
  endfunction

  task automatic do_reset;
    reset = 1'b1; InstrReady = 1'b0; MemReady = 1'b0; Zero = 1'b0;
    PCReg = 8'h00; Instruction = 32'h0;
    tick; tick;
    reset = 1'b0;
    #1;
    mpc = 8'h00;
    chk("rst_instrreq", 32'(InstrReq), 32'd1);
    chk("rst_instraddr", 32'(InstrAddr), 32'h0);
    chk("rst_halted", 32'(Halted), 32'd0);
    chk("rst_strobes", {RegWrite, MemReq, MemWrite, MemtoReg, link}, 32'd0);
  endtask

  // Fetch with fwait idle cycles, then present ins on the ready cycle.
  task automatic fetch(input logic [31:0] ins, input int fwait);
    for (int i = 0; i < fwait; i++) begin
      InstrReady = 1'b0; Instruction = $urandom; MemReady = 1'($urandom);
      #1;
      chk("fetch_wait_req", 32'(InstrReq), 32'd1);
      chk("fetch_wait_addr", 32'(InstrAddr), 32'(mpc));
      tick;
    end
    InstrReady = 1'b1; Instruction = ins; MemReady = 1'($urandom);
    #1;
    chk("fetch_req", 32'(InstrReq), 32'd1);
    chk("fetch_addr", 32'(InstrAddr), 32'(mpc));
    chk("fetch_strobes", {RegWrite, MemReq, MemWrite, MemtoReg, link}, 32'd0);
    tick;
  endtask

  // One legal instruction through its whole schedule, PC tracked by the model.
  task automatic run_instr(input int k, input int rd, input int rs1, input int rs2,
                           input int imm, input int fwait, input int mwait,
                           input logic zero, input logic [7:0] pcreg,
                           input logic rst_in_mem);
    logic [7:0] expimm;
    logic       wr, isjump, ismem;
    expimm = (k == K_SRAI) ? 8'(imm + 1024) : 8'(imm);
    wr     = (k == K_ADDI || k == K_SRAI || k == K_ADD || k == K_JAL || k == K_JALR);
    isjump = (k == K_JAL || k == K_JALR);
    ismem  = (k == K_LW || k == K_SW);
    fetch(enc(k, rd, rs1, rs2, imm), fwait);
    // DECODE
    InstrReady = 1'($urandom); Instruction = $urandom; MemReady = 1'($urandom);
    #1;
    chk("dec_instrreq", 32'(InstrReq), 32'd0);
    chk("dec_strobes", {RegWrite, MemReq, MemWrite, MemtoReg, link}, 32'd0);
    chk("dec_halted", 32'(Halted), 32'd0);
    if (k != K_BEQ && k != K_SW) chk("dec_rd", 32'(RD), 32'(rd & 31));
    if (k != K_JAL) chk("dec_rs1", 32'(RS1), 32'(rs1 & 31));
    if (k == K_ADD || k == K_SW || k == K_BEQ) chk("dec_rs2", 32'(RS2), 32'(rs2 & 31));
    if (k != K_ADD) chk("dec_imm", 32'(IMM), 32'(expimm));
    tick;
    // EXEC
    Zero = zero; PCReg = pcreg; InstrReady = 1'($urandom); MemReady = 1'($urandom);
    #1;
    chk("exec_regwrite", 32'(RegWrite), 32'(wr));
    chk("exec_link", 32'(link), 32'(isjump));
    chk("exec_mem", {MemReq, MemWrite, MemtoReg, InstrReq}, 32'd0);
    chk("exec_pclink", 32'(pclink), 32'(8'(mpc + 8'd4)));
    chk("exec_pc", 32'(PC), 32'(mpc));
    if (k != K_JAL) begin
      chk("exec_aluctl", 32'(ALUControl),
          (k == K_SRAI) ? 32'd13 : (k == K_BEQ) ? 32'd6 : 32'd2);
      chk("exec_alusrc", 32'(ALUSrc), 32'(k != K_ADD && k != K_BEQ));
    end
    tick;
    Zero = 1'b0;
    if (ismem) begin
      for (int i = 0; i <= mwait; i++) begin
        MemReady = (i == mwait); InstrReady = 1'($urandom);
        #1;
        chk("mem_req", 32'(MemReq), 32'd1);
        chk("mem_write", 32'(MemWrite), 32'(k == K_SW));
        chk("mem_regwrite", 32'(RegWrite), 32'(k == K_LW && MemReady));
        chk("mem_memtoreg", 32'(MemtoReg), 32'(k == K_LW && MemReady));
        chk("mem_link", 32'(link), 32'd0);
        if (rst_in_mem) begin
          reset = 1'b1; MemReady = 1'b1;
          tick;
          reset = 1'b0; MemReady = 1'b0;
          #1;
          mpc = 8'h00;
          chk("memrst_memreq", 32'(MemReq), 32'd0);
          chk("memrst_regwrite", 32'(RegWrite), 32'd0);
          chk("memrst_instrreq", 32'(InstrReq), 32'd1);
          chk("memrst_addr", 32'(InstrAddr), 32'd0);
          return;
        end
        tick;
      end
    end
    MemReady = 1'b0; InstrReady = 1'b0;
    case (k)
      K_BEQ:   mpc = zero ? 8'(mpc + 8'(imm)) : 8'(mpc + 8'd4);
      K_JAL:   mpc = 8'(mpc + 8'(imm));
      K_JALR:  mpc = 8'(pcreg + 8'(imm)) & 8'hFE;
      default: mpc = 8'(mpc + 8'd4);
    endcase
    #1;
    chk("next_pc", 32'(PC), 32'(mpc));
  endtask

  task automatic run_illegal(input logic [31:0] ins);
    logic [7:0] frozen;
    frozen = mpc;
    fetch(ins, 0);
    InstrReady = 1'b0;
    #1;
    chk("ill_dec_halted", 32'(Halted), 32'd0);
    tick;
    for (int i = 0; i < 3; i++) begin
      InstrReady = 1'b1; MemReady = 1'b1; Instruction = $urandom;
      #1;
      chk("halt_flag", 32'(Halted), 32'd1);
      chk("halt_strobes", {InstrReq, RegWrite, MemReq, MemWrite, MemtoReg, link}, 32'd0);
      chk("halt_pc", 32'(PC), 32'(frozen));
      tick;
    end
    InstrReady = 1'b0; MemReady = 1'b0;
  endtask

  initial begin
    int k, imm;
    // addi x1,x0,5 then lw x2,8(x1) with a 3-cycle memory stall
    do_reset;
    run_instr(K_ADDI, 1, 0, 0, 5, 0, 0, 1'b0, 8'h00, 1'b0);
    chk("addi_pc4", 32'(PC), 32'd4);
    run_instr(K_LW, 2, 1, 0, 8, 0, 3, 1'b0, 8'h00, 1'b0);
    chk("lw_pc8", 32'(PC), 32'd8);
    // beq taken backwards from 0 wraps; not taken falls through
    do_reset;
    run_instr(K_BEQ, 0, 1, 2, -8, 1, 0, 1'b1, 8'h00, 1'b0);
    chk("beq_wrap", 32'(PC), 32'hF8);
    do_reset;
    run_instr(K_BEQ, 0, 1, 2, -8, 0, 0, 1'b0, 8'h00, 1'b0);
    chk("beq_nt", 32'(PC), 32'h04);
    // jal to 0x10, then jalr x1,3(x5) with PCReg=0x20
    do_reset;
    run_instr(K_JAL, 0, 0, 0, 16, 0, 0, 1'b0, 8'h00, 1'b0);
    run_instr(K_JALR, 1, 5, 0, 3, 2, 0, 1'b0, 8'h20, 1'b0);
    chk("jalr_target", 32'(PC), 32'h22);
    // illegal encodings trap until reset
    do_reset;
    run_illegal(32'h0000_0000);
    do_reset;
    run_illegal(32'h4000_0033);
    do_reset;
    run_illegal(32'h0000_5013);
    do_reset;
    run_illegal(32'h0000_1013);
    // reset while waiting in MEM
    do_reset;
    run_instr(K_SW, 0, 3, 4, 12, 0, 2, 1'b0, 8'h00, 1'b1);
    do_reset;
    run_instr(K_LW, 7, 3, 0, -4, 1, 2, 1'b0, 8'h00, 1'b1);
    // random legal instruction stream
    do_reset;
    for (int n = 0; n < 60; n++) begin
      k = int'($urandom_range(0, 7));
      case (k)
        K_BEQ:   imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
        K_JAL:   imm = (int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2;
        K_SRAI:  imm = int'($urandom_range(0, 31));
        default: imm = int'($urandom_range(0, 4095)) - 2048;
      endcase
      run_instr(k, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 31)), imm, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'($urandom), 8'($urandom), 1'b0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
